// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap/mret sequencer for the single-cycle RV64I core.
// Optional: define CSR_MCOUNTINHIBIT_EN to add mcountinhibit (0x320) with CY/IR freeze bits.
module csr_unit #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0,
    parameter logic [XLEN-1:0] HART_ID   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            csr_wen_i,
    input  logic [11:0]     csr_idx_i,
    input  logic [5:0]      csr_info_i,
    input  logic [XLEN-1:0] csr_rs1_rdata_i,
    input  logic [4:0]      csr_zimm_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            mret_i,
    input  logic            ilegl_instr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_pc_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA     = 12'h301, A_MIE    = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC   = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342, A_MTVAL    = 12'h343, A_MIP    = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00, A_MINSTRET = 12'hB02, A_MHARTID = 12'hF14;
    localparam logic [11:0] A_MCOUNTINH = 12'h320;
    localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);
    // MXL=2 (64-bit) plus the 'I' extension bit
    localparam logic [XLEN-1:0] MISA_VAL = {2'b10, {(XLEN-2){1'b0}}} | XLEN'(9'h100);

    logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            cy_inh, ir_inh;
`ifdef CSR_MCOUNTINHIBIT_EN
    logic [XLEN-1:0] mcinh_q, mcinh_d;
    assign cy_inh = mcinh_q[0];
    assign ir_inh = mcinh_q[2];
`else
    assign cy_inh = 1'b0;
    assign ir_inh = 1'b0;
`endif

    logic [XLEN-1:0] old_val, src, new_val;
    logic            impl, is_rw, is_rs, is_imm, wr_intent, ro_addr;
    logic            csr_illegal, trap, mret_take, csr_we;

    always_comb begin
        old_val = '0;
        impl    = 1'b1;
        case (csr_idx_i)
            A_MSTATUS: begin
                old_val[3]     = st_mie_q;
                old_val[7]     = st_mpie_q;
                old_val[12:11] = 2'b11;
            end
            A_MISA:     old_val = MISA_VAL;
            A_MIE:      old_val = mie_q;
            A_MTVEC:    old_val = mtvec_q;
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MTVAL:    old_val = mtval_q;
            A_MIP:      old_val = '0;
            A_MCYCLE:   old_val = mcycle_q;
            A_MINSTRET: old_val = minstret_q;
            A_MHARTID:  old_val = HART_ID;
`ifdef CSR_MCOUNTINHIBIT_EN
            A_MCOUNTINH: old_val = mcinh_q;
`endif
            default:    impl = 1'b0;
        endcase
    end

    assign is_rw   = csr_info_i[5] | csr_info_i[2];
    assign is_rs   = csr_info_i[4] | csr_info_i[1];
    assign is_imm  = |csr_info_i[2:0];
    assign src     = is_imm ? XLEN'(csr_zimm_i) : csr_rs1_rdata_i;
    assign new_val = is_rw ? src : (is_rs ? (old_val | src) : (old_val & ~src));
    // set/clear forms with a zero rs1/zimm field are pure reads
    assign wr_intent = is_rw | ((is_rs | csr_info_i[3] | csr_info_i[0]) & (csr_zimm_i != 5'd0));
    assign ro_addr   = (csr_idx_i[11:10] == 2'b11) || (csr_idx_i == A_MISA) || (csr_idx_i == A_MIP);

    assign csr_illegal = instr_valid_i & csr_wen_i & (~impl | (wr_intent & ro_addr));
    assign trap        = instr_valid_i & (ecall_i | ebreak_i | ilegl_instr_i | csr_illegal);
    assign mret_take   = instr_valid_i & mret_i & ~trap;
    assign csr_we      = instr_valid_i & csr_wen_i & wr_intent & ~trap;
    assign csr_rdata_o = (csr_wen_i && !csr_illegal) ? old_val : '0;

    always_comb begin
        trap_valid_o = 1'b0;
        trap_pc_o    = '0;
        if (!rst && trap) begin
            trap_valid_o = 1'b1;
            trap_pc_o    = {mtvec_q[XLEN-1:2], 2'b00};
        end else if (!rst && mret_take) begin
            trap_valid_o = 1'b1;
            trap_pc_o    = mepc_q;
        end
    end

    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = cy_inh ? mcycle_q : mcycle_q + XLEN'(1);
        minstret_d = (instr_valid_i && !trap && !ir_inh) ? minstret_q + XLEN'(1) : minstret_q;
`ifdef CSR_MCOUNTINHIBIT_EN
        mcinh_d    = mcinh_q;
`endif
        // an explicit counter write overrides the increment computed above
        if (csr_we) begin
            case (csr_idx_i)
                A_MSTATUS: begin
                    st_mie_d  = new_val[3];
                    st_mpie_d = new_val[7];
                end
                A_MIE:      mie_d      = new_val & MIE_MASK;
                A_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = new_val;
                A_MTVAL:    mtval_d    = new_val;
                A_MCYCLE:   mcycle_d   = new_val;
                A_MINSTRET: minstret_d = new_val;
`ifdef CSR_MCOUNTINHIBIT_EN
                A_MCOUNTINH: mcinh_d   = new_val & XLEN'(3'b101);
`endif
                default: ;
            endcase
        end
        if (trap) begin
            mepc_d    = {pc_i[XLEN-1:2], 2'b00};
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            if (ilegl_instr_i || csr_illegal) begin
                mcause_d = XLEN'(2);
                mtval_d  = XLEN'(instr_i);
            end else if (ebreak_i) begin
                mcause_d = XLEN'(3);
                mtval_d  = pc_i;
            end else begin
                mcause_d = XLEN'(11);
                mtval_d  = '0;
            end
        end else if (mret_take) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RST[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
`ifdef CSR_MCOUNTINHIBIT_EN
            mcinh_q    <= '0;
`endif
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`ifdef CSR_MCOUNTINHIBIT_EN
            mcinh_q    <= mcinh_d;
`endif
        end
    end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file and trap sequencer for the single-cycle RV64I core.
- Acts as the responder for the decode stage's CSR request: CSR index, read/write enable, and one-hot CSR op.
- Consumes decode's exception flags (ecall/ebreak/mret/illegal).
- Returns the old CSR value for writeback and produces the PC redirect for traps and mret.

Parameters:
- XLEN, 64, datapath width.
- MTVEC_RST, 64'h0, reset value of mtvec base.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- instr_valid_i  in  1  the current instruction commits this cycle; all state updates are gated by it.
- pc_i  in  XLEN  PC of the current instruction.
- instr_i  in  32  raw instruction, used for mtval on illegal.
- csr_wen_i  in  1  CSR access request (read and write).
- csr_idx_i  in  12  CSR address.
- csr_info_i  in  6  one-hot {csrrw,csrrs,csrrc,csrrwi,csrrsi,csrrci}.
- csr_rs1_rdata_i  in  XLEN  rs1 value.
- csr_zimm_i  in  5  instr[19:15]; serves as both the rs1 index and zimm.
- ecall_i, ebreak_i, mret_i, ilegl_instr_i  in  1 each  exception flags from decode.
- csr_rdata_o  out  XLEN  old value of the addressed CSR (combinational).
- trap_valid_o  out  1  redirect fetch this cycle.
- trap_pc_o  out  XLEN  redirect target.

Behaviour:
- **Implemented CSRs:**
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] hardwired 2'b11; all other bits read 0.
  - misa 0x301: read-only {2'b10, I bit}.
  - mie 0x304: bits 3, 7, 11 writable; others 0.
  - mtvec 0x305: mode[1:0] forced 2'b00.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, mtval 0x343.
  - mip 0x344: read-only 0.
  - mcycle 0xB00, minstret 0xB02.
  - mhartid 0xF14: read-only.
- **Reset values:** mstatus = 64'h1800, mtvec = MTVEC_RST, all other CSRs 0. While rst=1, trap_valid_o=0 and trap_pc_o=0.
- **Read:** csr_rdata_o = old value of csr_idx_i when csr_wen_i=1; otherwise 0. Reads have zero latency.
- **Write source:** src = csr_rs1_rdata_i for register forms; src = zero-extended zimm for immediate forms.
  - rw: new = src.
  - rs: new = old | src.
  - rc: new = old & ~src.
  - For rs/rc/rsi/rci with csr_zimm_i == 0: no write.
  - The write lands at the next clk edge.
- **Illegal CSR access** (csr_wen_i=1 and instr_valid_i=1): either the index is unimplemented, or a write would occur to a read-only address (idx[11:10] == 2'b11, misa, mip).
  - Response: no CSR write, csr_rdata_o = 0, trap taken with cause 2.
- **Trap entry** (instr_valid_i, and any of ecall / ebreak / ilegl_instr / illegal CSR):
  - Combinationally: trap_valid_o = 1, trap_pc_o = {mtvec[XLEN-1:2], 2'b00}.
  - Next edge: mepc <= pc_i; MPIE <= MIE; MIE <= 0.
  - mcause and mtval by cause:
    - ecall: mcause 11, mtval 0.
    - ebreak: mcause 3, mtval pc_i.
    - illegal: mcause 2, mtval {32'b0, instr_i}.
  - Priority when several flags are set: illegal > ebreak > ecall.
  - A trap suppresses the CSR write.
- **mret** (instr_valid_i, no trap):
  - Combinationally: trap_valid_o = 1, trap_pc_o = mepc.
  - Next edge: MIE <= MPIE; MPIE <= 1.
- **mcycle:** increments every cycle not in reset.
- **minstret:** increments when instr_valid_i=1 and no trap is taken (mret counts as retired).
- **Counter edge cases:**
  - A CSR write to a counter in the same cycle wins; there is no increment that cycle.
  - Counters wrap 2^64-1 -> 0.
- **instr_valid_i=0:** no state change except mcycle; trap_valid_o = 0.
- **Reset asserted mid-operation:** overrides any pending write or trap at that edge.

Optional Feature:
- Macro: CSR_MCOUNTINHIBIT_EN.
- **Defined:** adds mcountinhibit 0x320 with bit0 CY and bit2 IR writable, all other bits 0, reset 0.
  - CY=1 freezes mcycle; IR=1 freezes minstret.
  - Explicit writes to a frozen counter still take effect.
- **Undefined:** 0x320 is unimplemented, so access is illegal (cause 2), and the counters always run.

Test Plan:
- **Reset:** rst high 2 cycles, release -> read 0x300 returns 64'h1800, 0x305 returns MTVEC_RST, 0x341 returns 0, trap_valid_o = 0.
- **csrrw/csrrs/csrrc:**
  - csrrw 0x340 with rs1 = 64'hDEAD_BEEF -> csr_rdata_o = 0 that cycle; next read returns 64'hDEAD_BEEF.
  - csrrs with src 64'hF0 -> 64'hDEAD_BEFF.
  - csrrc with zimm 0 -> no change.
- **ecall at pc 64'h8000_0010 with mtvec = 64'h8000_0103:**
  - Same cycle: trap_valid_o = 1, trap_pc_o = 64'h8000_0100.
  - After: mepc = 64'h8000_0010, mcause = 11, MIE 1->0, MPIE = 1.
- **mret after that trap** -> trap_pc_o = 64'h8000_0010; MIE = 1, MPIE = 1.
- **csrrw to 0xF14 at pc 64'h100 with instr 32'hF1401073** -> no write; mcause = 2, mtval = 64'hF1401073; minstret unchanged.
- **Counters:**
  - Write mcycle = 64'hFFFF_FFFF_FFFF_FFFF, then idle 1 cycle -> reads 0.
  - Write minstret = 5 with instr_valid_i = 1 -> next read 5, not 6.
